// File: rtl/mem_arb_pkg.sv
// Shared types for the I/D memory bus arbiter: FSM states, owner encoding,
// latched request record and transfer-size codes.
package mem_arb_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {IDLE, ADDR, DATA} arb_state_t;
    typedef enum logic {OWN_I, OWN_D} owner_t;

    typedef struct packed {
        logic              wr;
        logic [1:0]        size;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/mem_bus_arbiter_pick.sv
// Combinational winner select between fetch and memory stage requests.
// MEM_ARB_RR_EN selects round-robin ties; otherwise fixed priority by D_PRIORITY.
import mem_arb_pkg::*;

module arb_pick #(
    parameter bit D_PRIORITY = 1'b1
) (
    input  logic i_req,
    input  logic d_req,
    input  logic last_owner,
    output logic grant_vld,
    output logic grant_d
);
    logic tie_d;

`ifdef MEM_ARB_RR_EN
    // The side that completed last yields the next tie.
    assign tie_d = (last_owner == logic'(OWN_I));
    logic unused_prio;
    assign unused_prio = D_PRIORITY;
`else
    assign tie_d = D_PRIORITY;
    logic unused_last;
    assign unused_last = last_owner;
`endif

    assign grant_vld = i_req | d_req;
    assign grant_d   = d_req & (~i_req | tie_d);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one SRAM-like bus between fetch (I) and memory (D) stages, one
// outstanding transaction at a time. Optional MEM_ARB_RR_EN: round-robin ties.
import mem_arb_pkg::*;

module mem_bus_arbiter #(
    parameter int AW         = ADDR_W,
    parameter int DW         = DATA_W,
    parameter bit D_PRIORITY = 1'b1
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_addr_ok,
    output logic          i_data_ok,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_wr,
    input  logic [1:0]    d_size,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_addr_ok,
    output logic          d_data_ok,
    output logic [DW-1:0] d_rdata,
    output logic          bus_req,
    output logic          bus_wr,
    output logic [1:0]    bus_size,
    output logic [AW-1:0] bus_addr,
    output logic [DW-1:0] bus_wdata,
    input  logic          bus_addr_ok,
    input  logic          bus_data_ok,
    input  logic [DW-1:0] bus_rdata
);
    arb_state_t state_q, state_d;
    owner_t     owner_q, owner_d;
    owner_t     last_q, last_d;
    mem_req_t   req_q, req_d;
    logic       bus_req_q, bus_req_d;
    logic       grant_vld, grant_d;
    logic       addr_hs, data_hs;

    arb_pick #(.D_PRIORITY(D_PRIORITY)) u_pick (
        .i_req      (i_req),
        .d_req      (d_req),
        .last_owner (last_q),
        .grant_vld  (grant_vld),
        .grant_d    (grant_d)
    );

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        req_d     = req_q;
        bus_req_d = bus_req_q;
        case (state_q)
            IDLE: if (grant_vld) begin
                state_d   = ADDR;
                bus_req_d = 1'b1;
                if (grant_d) begin
                    owner_d = OWN_D;
                    req_d   = '{wr: d_wr, size: d_size, addr: d_addr, wdata: d_wdata};
                end else begin
                    owner_d = OWN_I;
                    req_d   = '{wr: 1'b0, size: SZ_WORD, addr: i_addr, wdata: '0};
                end
            end
            ADDR: if (bus_addr_ok) begin
                state_d   = DATA;
                bus_req_d = 1'b0;
            end
            DATA: if (bus_data_ok) begin
                state_d = IDLE;
                last_d  = owner_q;
            end
            default: begin
                state_d   = IDLE;
                bus_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= IDLE;
            owner_q   <= OWN_I;
            last_q    <= OWN_I;
            req_q     <= '0;
            bus_req_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            req_q     <= req_d;
            bus_req_q <= bus_req_d;
        end
    end

    // Handshakes are only honoured in their own phase; strays are dropped.
    assign addr_hs = (state_q == ADDR) & bus_addr_ok;
    assign data_hs = (state_q == DATA) & bus_data_ok;

    assign i_addr_ok = addr_hs & (owner_q == OWN_I);
    assign d_addr_ok = addr_hs & (owner_q == OWN_D);
    assign i_data_ok = data_hs & (owner_q == OWN_I);
    assign d_data_ok = data_hs & (owner_q == OWN_D);
    assign i_rdata   = i_data_ok ? bus_rdata : '0;
    assign d_rdata   = d_data_ok ? bus_rdata : '0;

    assign bus_req   = bus_req_q;
    assign bus_wr    = req_q.wr;
    assign bus_size  = req_q.size;
    assign bus_addr  = req_q.addr;
    assign bus_wdata = req_q.wdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized bench for mem_bus_arbiter against a transaction-level model.
// Build with MEM_ARB_RR_EN defined to check the round-robin variant.
module tb_mem_bus_arbiter;
    import mem_arb_pkg::*;

    localparam bit D_PRIORITY = 1'b1;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        i_req = 0, d_req = 0, d_wr = 0;
    logic [31:0] i_addr = 0, d_addr = 0, d_wdata = 0;
    logic [1:0]  d_size = 0;
    logic        i_addr_ok, i_data_ok, d_addr_ok, d_data_ok;
    logic [31:0] i_rdata, d_rdata;
    logic        bus_req, bus_wr;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr, bus_wdata;
    logic        bus_addr_ok = 0, bus_data_ok = 0;
    logic [31:0] bus_rdata = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.AW(32), .DW(32), .D_PRIORITY(D_PRIORITY)) dut (
        .clk(clk), .resetn(resetn),
        .i_req(i_req), .i_addr(i_addr), .i_addr_ok(i_addr_ok),
        .i_data_ok(i_data_ok), .i_rdata(i_rdata),
        .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok),
        .d_rdata(d_rdata),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
    );

    int errs = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Transaction-level model: which side owns the bus and which phase it waits in.
    bit     m_busy = 0, m_data = 0;
    owner_t m_own = OWN_I, m_last = OWN_I;
    bit     m_wr;
    bit [1:0]  m_size;
    bit [31:0] m_addr, m_wdata;
    bit     s_pend = 0, i_drop = 0, d_drop = 0;
    int     n_ties = 0, n_done = 0;

    function automatic owner_t pick(bit ir, bit dr, owner_t last);
        if (ir && !dr) return OWN_I;
        if (dr && !ir) return OWN_D;
`ifdef MEM_ARB_RR_EN
        return (last == OWN_I) ? OWN_D : OWN_I;
`else
        return D_PRIORITY ? OWN_D : OWN_I;
`endif
    endfunction

    task automatic model_reset();
        m_busy = 0; m_data = 0; m_last = OWN_I;
        s_pend = 0; i_drop = 0; d_drop = 0;
    endtask

    // One clock of stimulus, checks and model update. force_dok: stray bus_data_ok.
    task automatic cycle(input bit rnd, input bit force_dok);
        bit exp_req, e_iao, e_dao, e_ido, e_ddo;
        owner_t w;
        @(posedge clk); #1;
        if (i_drop) begin i_req = 0; i_drop = 0; end
        if (d_drop) begin d_req = 0; d_drop = 0; end
        if (rnd && !i_req && ($urandom % 3 == 0)) begin
            i_req = 1; i_addr = $urandom;
        end
        if (rnd && !d_req && ($urandom % 3 == 0)) begin
            d_req = 1; d_wr = $urandom; d_size = 2'($urandom % 3);
            d_addr = $urandom; d_wdata = $urandom;
        end
        bus_addr_ok = bus_req ? ($urandom % 3 == 0) : ($urandom % 8 == 0);
        bus_data_ok = force_dok ? 1'b1 :
                      (s_pend ? ($urandom % 3 == 0) : ($urandom % 8 == 0));
        bus_rdata   = $urandom;
        #1;
        exp_req = m_busy && !m_data;
        chk("bus_req", bus_req, exp_req);
        if (exp_req) begin
            chk("bus_wr", bus_wr, m_wr);
            chk("bus_size", bus_size, m_size);
            chk("bus_addr", bus_addr, m_addr);
            if (m_own == OWN_D) chk("bus_wdata", bus_wdata, m_wdata);
        end
        e_iao = exp_req && bus_addr_ok && m_own == OWN_I;
        e_dao = exp_req && bus_addr_ok && m_own == OWN_D;
        e_ido = m_busy && m_data && bus_data_ok && m_own == OWN_I;
        e_ddo = m_busy && m_data && bus_data_ok && m_own == OWN_D;
        chk("i_addr_ok", i_addr_ok, e_iao);
        chk("d_addr_ok", d_addr_ok, e_dao);
        chk("i_data_ok", i_data_ok, e_ido);
        chk("d_data_ok", d_data_ok, e_ddo);
        if (e_ido) chk("i_rdata", i_rdata, bus_rdata);
        if (e_ddo) chk("d_rdata", d_rdata, bus_rdata);
        if (!m_busy) begin
            if (i_req || d_req) begin
                if (i_req && d_req) n_ties++;
                w = pick(i_req, d_req, m_last);
                m_own = w; m_busy = 1; m_data = 0;
                if (w == OWN_D) begin
                    m_wr = d_wr; m_size = d_size; m_addr = d_addr; m_wdata = d_wdata;
                end else begin
                    m_wr = 0; m_size = SZ_WORD; m_addr = i_addr;
                end
            end
        end else if (!m_data) begin
            if (bus_addr_ok) begin
                m_data = 1;
                if (m_own == OWN_I) i_drop = 1; else d_drop = 1;
            end
        end else if (bus_data_ok) begin
            m_busy = 0; m_last = m_own; n_done++;
        end
        if (bus_req && bus_addr_ok) s_pend = 1;
        else if (s_pend && bus_data_ok) s_pend = 0;
    endtask

    initial begin
        bit reached;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_bus_req", bus_req, 0);
        chk("rst_fields", {bus_wr, bus_size, bus_addr, bus_wdata}, 0);
        chk("rst_ok", {i_addr_ok, i_data_ok, d_addr_ok, d_data_ok}, 0);
        chk("rst_rdata", {i_rdata, d_rdata}, 0);
        resetn = 1;
        model_reset();

        // Stray data_ok in IDLE must be ignored.
        cycle(0, 1);
        cycle(0, 1);

        repeat (2000) cycle(1, 0);

        // Reset while in DATA, then a stale bus_data_ok right after release.
        reached = 0;
        for (int k = 0; k < 300 && !reached; k++) begin
            cycle(1, 0);
            reached = m_busy && m_data;
        end
        chk("reach_data", reached, 1);
        @(posedge clk); #1;
        resetn = 0; i_req = 0; d_req = 0; bus_addr_ok = 0; bus_data_ok = 0;
        @(posedge clk); #1;
        resetn = 1;
        model_reset();
        chk("post_rst_bus_req", bus_req, 0);
        cycle(0, 1);
        cycle(0, 0);

        repeat (2000) cycle(1, 0);
        chk("saw_ties", n_ties > 10, 1);
        chk("saw_done", n_done > 100, 1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
